// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous RAM between instruction fetch and data load/store.
//
// Ports
//   clk, rst_n                      clock (rising edge), asynchronous active-low reset
//   if_req/if_addr                  fetch read request, held until if_gnt
//   if_gnt/if_rvalid/if_rdata       fetch grant, read-data strobe, read data
//   dm_req/dm_read_wrn/dm_addr/
//   dm_wdata                        data request (1 = load, 0 = store), held until dm_gnt
//   dm_gnt/dm_rvalid/dm_rdata       data grant, load-data strobe, load data
//   mem_en/mem_read_wrn/mem_addr/
//   mem_wdata/mem_rdata             RAM access strobe, direction, address, write data, read data
//   cpu_stall                       pipeline must hold this cycle
module mem_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int RD_LATENCY   = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_read_wrn,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_read_wrn,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_stall
);

    typedef enum logic {IDLE, RD_WAIT} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;

    state_t     state_q, state_d;
    owner_t     owner_q, owner_d;
    logic [2:0] lat_cnt_q, lat_cnt_d;
    logic [3:0] dm_streak_q, dm_streak_d;
    logic       idle, starved, rd_done;

    always_comb begin
        // Grants are gated by rst_n so every output sits at its reset value while reset is held.
        idle         = rst_n && state_q == IDLE;
        starved      = dm_streak_q == 4'(STARVE_LIMIT);
        if_gnt       = idle && if_req && (starved || !dm_req);
        dm_gnt       = idle && dm_req && !(if_req && starved);
        rd_done      = state_q == RD_WAIT && lat_cnt_q == 3'(RD_LATENCY);
        if_rvalid    = rd_done && owner_q == OWN_IF;
        dm_rvalid    = rd_done && owner_q == OWN_DM;
        if_rdata     = if_rvalid ? mem_rdata : '0;
        dm_rdata     = dm_rvalid ? mem_rdata : '0;
        mem_en       = if_gnt || dm_gnt;
        mem_read_wrn = dm_gnt ? dm_read_wrn : 1'b1;
        mem_addr     = if_gnt ? if_addr : dm_gnt ? dm_addr : '0;
        mem_wdata    = dm_gnt ? dm_wdata : '0;
        cpu_stall    = rst_n && ((if_req && !if_gnt) || (dm_req && !dm_gnt) ||
                                 (state_q == RD_WAIT && !rd_done));
        state_d      = state_q;
        owner_d      = owner_q;
        lat_cnt_d    = lat_cnt_q;
        if (state_q == RD_WAIT) begin
            state_d   = rd_done ? IDLE : RD_WAIT;
            owner_d   = rd_done ? OWN_NONE : owner_q;
            lat_cnt_d = rd_done ? 3'd0 : lat_cnt_q + 3'd1;
        end else if (if_gnt || (dm_gnt && dm_read_wrn)) begin
            // Stores complete in the grant cycle; only reads wait for the RAM.
            state_d   = RD_WAIT;
            owner_d   = if_gnt ? OWN_IF : OWN_DM;
            lat_cnt_d = 3'd1;
        end
        // The streak only matters while fetch is waiting, so it restarts whenever fetch is idle or served.
        dm_streak_d = (!if_req || if_gnt) ? 4'd0 :
                      (dm_gnt && !starved) ? dm_streak_q + 4'd1 : dm_streak_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= OWN_NONE;
            lat_cnt_q   <= '0;
            dm_streak_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lat_cnt_q   <= lat_cnt_d;
            dm_streak_q <= dm_streak_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter (instance 0: RD_LATENCY 1, instance 1: RD_LATENCY 3).
module tb_mem_port_arbiter;

    logic        clk = 0;
    logic        rst_n;
    logic        if_req [2];
    logic [15:0] if_addr [2];
    logic        if_gnt [2];
    logic        if_rvalid [2];
    logic [31:0] if_rdata [2];
    logic        dm_req [2];
    logic        dm_read_wrn [2];
    logic [15:0] dm_addr [2];
    logic [31:0] dm_wdata [2];
    logic        dm_gnt [2];
    logic        dm_rvalid [2];
    logic [31:0] dm_rdata [2];
    logic        mem_en [2];
    logic        mem_read_wrn [2];
    logic [15:0] mem_addr [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic        cpu_stall [2];
    logic [15:0] last_addr [2];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        int          inst;
        bit          port;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t q[$];

    for (genvar g = 0; g < 2; g++) begin : u
        mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LATENCY((g == 0) ? 1 : 3), .STARVE_LIMIT(4)) dut (
            .clk(clk), .rst_n(rst_n),
            .if_req(if_req[g]), .if_addr(if_addr[g]), .if_gnt(if_gnt[g]),
            .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
            .dm_req(dm_req[g]), .dm_read_wrn(dm_read_wrn[g]), .dm_addr(dm_addr[g]),
            .dm_wdata(dm_wdata[g]), .dm_gnt(dm_gnt[g]), .dm_rvalid(dm_rvalid[g]),
            .dm_rdata(dm_rdata[g]), .mem_en(mem_en[g]), .mem_read_wrn(mem_read_wrn[g]),
            .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]),
            .cpu_stall(cpu_stall[g])
        );
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] model(logic [15:0] a);
        return (a == 16'h0040) ? 32'h0000_0013 : {a, ~a};
    endfunction

    // RAM model: read data for the last read address stays on mem_rdata until the next read.
    always @(posedge clk or negedge rst_n)
        for (int k = 0; k < 2; k++)
            if (!rst_n) last_addr[k] <= '0;
            else if (mem_en[k] && mem_read_wrn[k]) last_addr[k] <= mem_addr[k];

    always_comb
        for (int k = 0; k < 2; k++) mem_rdata[k] = model(last_addr[k]);

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_out(int k, string t, bit ig, bit dg, bit en, bit rw, logic [15:0] a, logic [31:0] wd, bit st);
        chk({t, " if_gnt"}, 64'(if_gnt[k]), 64'(ig));
        chk({t, " dm_gnt"}, 64'(dm_gnt[k]), 64'(dg));
        chk({t, " mem_en"}, 64'(mem_en[k]), 64'(en));
        chk({t, " mem_read_wrn"}, 64'(mem_read_wrn[k]), 64'(rw));
        chk({t, " mem_addr"}, 64'(mem_addr[k]), 64'(a));
        chk({t, " mem_wdata"}, 64'(mem_wdata[k]), 64'(wd));
        chk({t, " cpu_stall"}, 64'(cpu_stall[k]), 64'(st));
    endtask

    task automatic chk_reset(string t);
        for (int k = 0; k < 2; k++) begin
            chk_out(k, t, 0, 0, 0, 1, 16'h0, 32'h0, 0);
            chk({t, " if_rvalid"}, 64'(if_rvalid[k]), 64'd0);
            chk({t, " dm_rvalid"}, 64'(dm_rvalid[k]), 64'd0);
            chk({t, " if_rdata"}, 64'(if_rdata[k]), 64'd0);
            chk({t, " dm_rdata"}, 64'(dm_rdata[k]), 64'd0);
        end
    endtask

    task automatic push(int k, bit p, logic [31:0] d, int lat);
        q.push_back('{k, p, d, cyc + lat});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Monitor: every rvalid must match the oldest expected response; overdue entries are failures.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (if_rvalid[k] && dm_rvalid[k]) chk("rvalid both", 64'd1, 64'd0);
            if (if_rvalid[k] || dm_rvalid[k]) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected rvalid inst %0d at cyc %0d: got if=%0b dm=%0b expected none", k, cyc, if_rvalid[k], dm_rvalid[k]);
                end else begin
                    e = q.pop_front();
                    chk("rsp inst", 64'(k), 64'(e.inst));
                    chk("rsp port", 64'(dm_rvalid[k]), 64'(e.port));
                    chk("rsp cycle", 64'(cyc), 64'(e.due));
                    chk("rsp data", 64'(dm_rvalid[k] ? dm_rdata[k] : if_rdata[k]), 64'(e.data));
                    chk("rsp other rdata", 64'(dm_rvalid[k] ? if_rdata[k] : dm_rdata[k]), 64'd0);
                end
            end
        end
        if (q.size() != 0 && cyc > q[0].due) begin
            total++;
            bad++;
            $display("FAIL missing rvalid inst %0d: got none by cyc %0d expected at %0d", q[0].inst, cyc, q[0].due);
            void'(q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit f;
        logic [15:0] a;
        rst_n = 0;
        for (int k = 0; k < 2; k++) begin
            if_req[k] = 0; if_addr[k] = 0; dm_req[k] = 0; dm_read_wrn[k] = 1;
            dm_addr[k] = 0; dm_wdata[k] = 0;
        end
        sample();
        chk_reset("por");
        step();
        rst_n = 1;
        sample();
        chk_reset("post_rst");

        // Lone fetch, latency 1; fetch stays requested to show the next grant lands at T+2.
        step(); if_req[0] = 1; if_addr[0] = 16'h0040;
        sample(); chk_out(0, "f_g1", 1, 0, 1, 1, 16'h0040, 0, 0); push(0, 0, 32'h0000_0013, 1);
        step(); if_addr[0] = 16'h0044;
        sample(); chk_out(0, "f_wait", 0, 0, 0, 1, 16'h0, 0, 1);
        step();
        sample(); chk_out(0, "f_g2", 1, 0, 1, 1, 16'h0044, 0, 0); push(0, 0, model(16'h0044), 1);
        step(); if_req[0] = 0;
        sample(); chk_out(0, "f_done", 0, 0, 0, 1, 16'h0, 0, 0);

        // Back-to-back stores: no response, second grant the very next cycle.
        step(); dm_req[0] = 1; dm_read_wrn[0] = 0; dm_addr[0] = 16'h0100; dm_wdata[0] = 32'hDEAD_BEEF;
        sample(); chk_out(0, "st1", 0, 1, 1, 0, 16'h0100, 32'hDEAD_BEEF, 0);
        step(); dm_addr[0] = 16'h0104; dm_wdata[0] = 32'h1234_5678;
        sample(); chk_out(0, "st2", 0, 1, 1, 0, 16'h0104, 32'h1234_5678, 0);
        step(); dm_req[0] = 0; dm_wdata[0] = 0;
        sample(); chk_out(0, "st_idle", 0, 0, 0, 1, 16'h0, 0, 0);

        // Contention: four loads then one forced fetch, twice.
        for (int s = 0; s < 10; s++) begin
            f = (s % 5) == 4;
            step();
            if_req[0] = 1; dm_req[0] = 1; dm_read_wrn[0] = 1;
            if_addr[0] = 16'h0200 + 16'(4 * s);
            dm_addr[0] = 16'h0300 + 16'(4 * s);
            a = f ? if_addr[0] : dm_addr[0];
            sample(); chk_out(0, "cont_g", f, !f, 1, 1, a, 0, 1); push(0, !f, model(a), 1);
            step();
            sample(); chk_out(0, "cont_w", 0, 0, 0, 1, 16'h0, 0, 1);
        end
        step(); if_req[0] = 0; dm_req[0] = 0;
        sample(); chk_out(0, "cont_end", 0, 0, 0, 1, 16'h0, 0, 0);

        // Latency 3 load.
        step(); dm_req[1] = 1; dm_read_wrn[1] = 1; dm_addr[1] = 16'h0500;
        sample(); chk_out(1, "l3_g", 0, 1, 1, 1, 16'h0500, 0, 0); push(1, 1, model(16'h0500), 3);
        step(); dm_req[1] = 0;
        sample(); chk_out(1, "l3_t1", 0, 0, 0, 1, 16'h0, 0, 1);
        step();
        sample(); chk_out(1, "l3_t2", 0, 0, 0, 1, 16'h0, 0, 1);
        step();
        sample(); chk_out(1, "l3_t3", 0, 0, 0, 1, 16'h0, 0, 0);
        step();
        sample(); chk_out(1, "l3_t4", 0, 0, 0, 1, 16'h0, 0, 0);

        // A store request dropped while a read is outstanding is never served.
        step(); dm_req[1] = 1; dm_read_wrn[1] = 1; dm_addr[1] = 16'h0600;
        sample(); chk_out(1, "drop_g", 0, 1, 1, 1, 16'h0600, 0, 0); push(1, 1, model(16'h0600), 3);
        step(); dm_read_wrn[1] = 0; dm_addr[1] = 16'h0700; dm_wdata[1] = 32'hAAAA_5555;
        sample(); chk_out(1, "drop_t1", 0, 0, 0, 1, 16'h0, 0, 1);
        step(); dm_req[1] = 0; dm_read_wrn[1] = 1; dm_wdata[1] = 0;
        sample(); chk_out(1, "drop_t2", 0, 0, 0, 1, 16'h0, 0, 1);
        step();
        sample(); chk_out(1, "drop_t3", 0, 0, 0, 1, 16'h0, 0, 0);
        step();
        sample(); chk_out(1, "drop_t4", 0, 0, 0, 1, 16'h0, 0, 0);

        // Reset in the middle of a latency-3 load: abandoned, no response, fresh grant after release.
        step(); dm_req[1] = 1; dm_read_wrn[1] = 1; dm_addr[1] = 16'h0800;
        sample(); chk_out(1, "rm_g", 0, 1, 1, 1, 16'h0800, 0, 0);
        step(); dm_req[1] = 0; rst_n = 0;
        sample(); chk_reset("rm_in");
        step(); step(); step();
        sample(); chk_reset("rm_hold");
        step(); rst_n = 1; if_req[1] = 1; if_addr[1] = 16'h0900;
        sample(); chk_out(1, "rm_fg", 1, 0, 1, 1, 16'h0900, 0, 0); push(1, 0, model(16'h0900), 3);
        step(); if_req[1] = 0;
        sample(); chk_out(1, "rm_t1", 0, 0, 0, 1, 16'h0, 0, 1);
        repeat (5) step();
        sample();
        chk("scoreboard empty", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
